// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I/Zicsr encoder, kind ordinal + operands -> 32-bit word with byte address
//   clk, rst_n (async, active low), clear (sync flush, rewinds address and error count)
//   in_valid/in_ready/in_kind/in_rd/in_rs1/in_rs2/in_imm/in_csr : request side, in_ready combinational
//   out_valid/out_ready/out_word/out_addr/out_err : encoded word side, fields stable while stalled
//   err_count : saturating count of erroneous words handed out
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [11:0]       in_csr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_SYS} fmt_t;
  fmt_t fmt_d, fmt_q;
  logic [6:0] op_d, op_q;
  logic [2:0] f3_d, f3_q;
  logic b30_d, b30_q, bad_d, bad_q;
  logic [31:0] imm_d, imm_q, w, word_d, word_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [5:0] t;
  logic s1_v_q, s2_v_q, s1_adv, s2_adv, err_q;
  logic i_ok, b_ok, j_ok;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0] cnt_q;
  // Range checks as sign-extension tests: the bits above the field's sign bit must all match it.
  assign i_ok = &in_imm[31:11] | ~|in_imm[31:11];
  assign b_ok = &in_imm[31:12] | ~|in_imm[31:12];
  assign j_ok = &in_imm[31:20] | ~|in_imm[31:20];
  assign s2_adv = !s2_v_q || out_ready;
  assign s1_adv = !s1_v_q || s2_adv;
  assign in_ready = s1_adv && !clear;
  assign out_valid = s2_v_q;
  assign out_word = word_q;
  assign out_addr = addr_q;
  assign out_err = err_q;
  assign err_count = cnt_q;
  // Kind ordinals follow the decoder's instr_kind_t order; f3 is derived from the offset within each group.
  always_comb begin
    fmt_d = F_I;
    op_d = 7'b0010011;
    f3_d = 3'd0;
    b30_d = 1'b0;
    bad_d = 1'b0;
    imm_d = in_imm;
    t = 6'd0;
    case (in_kind) inside
      6'd0, 6'd1: begin
        fmt_d = F_U;
        op_d = in_kind[0] ? 7'b0010111 : 7'b0110111;
        bad_d = |in_imm[11:0];
      end
      6'd2: begin
        fmt_d = F_J;
        op_d = 7'b1101111;
        bad_d = in_imm[0] || !j_ok;
      end
      6'd3: begin
        op_d = 7'b1100111;
        bad_d = !i_ok;
      end
      [6'd4:6'd9]: begin
        t = in_kind - 6'd4;
        fmt_d = F_B;
        op_d = 7'b1100011;
        f3_d = (t < 6'd2) ? t[2:0] : t[2:0] + 3'd2;
        bad_d = in_imm[0] || !b_ok;
      end
      [6'd10:6'd14]: begin
        t = in_kind - 6'd10;
        op_d = 7'b0000011;
        f3_d = (t < 6'd3) ? t[2:0] : t[2:0] + 3'd1;
        bad_d = !i_ok;
      end
      [6'd15:6'd17]: begin
        t = in_kind - 6'd15;
        fmt_d = F_S;
        op_d = 7'b0100011;
        f3_d = t[2:0];
        bad_d = !i_ok;
      end
      [6'd18:6'd23]: begin
        t = in_kind - 6'd18;
        f3_d = (t == 6'd0) ? 3'd0 : (t < 6'd4) ? t[2:0] + 3'd1 : t[2:0] + 3'd2;
        bad_d = !i_ok;
      end
      [6'd24:6'd26]: begin
        f3_d = (in_kind == 6'd24) ? 3'd1 : 3'd5;
        b30_d = in_kind == 6'd26;
        bad_d = |in_imm[31:5];
      end
      [6'd27:6'd36]: begin
        t = in_kind - 6'd27;
        fmt_d = F_R;
        op_d = 7'b0110011;
        f3_d = (t < 6'd2) ? 3'd0 : (t < 6'd6) ? t[2:0] - 3'd1 : (t < 6'd8) ? 3'd5 : t[2:0] - 3'd2;
        b30_d = (t == 6'd1) || (t == 6'd7);
      end
      6'd37: op_d = 7'b0001111;
      6'd38: begin
        fmt_d = F_SYS;
        op_d = 7'b0001111;
        f3_d = 3'd1;
        imm_d = '0;
      end
      6'd39, 6'd40: begin
        fmt_d = F_SYS;
        op_d = 7'b1110011;
        imm_d = {31'd0, in_kind[0] == 1'b0};
      end
      [6'd41:6'd46]: begin
        t = in_kind - 6'd41;
        op_d = 7'b1110011;
        f3_d = (t < 6'd3) ? t[2:0] + 3'd1 : t[2:0] + 3'd2;
        imm_d = {20'd0, in_csr};
      end
      default: bad_d = 1'b1;
    endcase
  end
  // CSR and fixed system words reuse the I layout; SYS kinds zero the register fields.
  always_comb begin
    case (fmt_q)
      F_R: w = {1'b0, b30_q, 5'd0, rs2_q, rs1_q, f3_q, rd_q, op_q};
      F_I: w = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q} | {1'b0, b30_q, 30'd0};
      F_S: w = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      F_B: w = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], op_q};
      F_U: w = {imm_q[31:12], rd_q, op_q};
      F_J: w = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
      default: w = {imm_q[11:0], 5'd0, f3_q, 5'd0, op_q};
    endcase
  end
  assign word_d = bad_q ? 32'd0 : w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      fmt_q <= F_I;
      op_q <= '0;
      f3_q <= '0;
      b30_q <= 1'b0;
      bad_q <= 1'b0;
      imm_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      word_q <= '0;
      err_q <= 1'b0;
      addr_q <= BASE_ADDR;
      cnt_q <= '0;
    end else if (clear) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      addr_q <= BASE_ADDR;
      cnt_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_valid;
        fmt_q <= fmt_d;
        op_q <= op_d;
        f3_q <= f3_d;
        b30_q <= b30_d;
        bad_q <= bad_d;
        imm_q <= imm_d;
        rd_q <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
      end
      if (s2_adv) s2_v_q <= s1_v_q;
      if (s2_adv && s1_v_q) begin
        word_q <= word_d;
        err_q <= bad_q;
      end
      if (s2_v_q && out_ready) begin
        addr_q <= addr_q + ADDR_W'(4);
        cnt_q <= cnt_q + {15'd0, err_q && (cnt_q != 16'hFFFF)};
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder (default and 8-bit wrapping instances)
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic clear1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [5:0] in_kind = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic [11:0] in_csr = '0;
  logic in_ready0, out_valid0, out_err0, in_ready1, out_valid1, out_err1;
  logic [31:0] out_word0, out_addr0, out_word1;
  logic [7:0] out_addr1;
  logic [15:0] err_count0, err_count1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_addr = '0;
  always #5 clk = ~clk;
  instr_encoder u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_csr(in_csr),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_word(out_word0), .out_addr(out_addr0),
    .out_err(out_err0), .err_count(err_count0)
  );
  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'hF8)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_csr(in_csr),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_word(out_word1), .out_addr(out_addr1),
    .out_err(out_err1), .err_count(err_count1)
  );
  task automatic put(input logic [5:0] k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [11:0] csr);
    in_kind = k;
    in_rd = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
    in_csr = csr;
  endtask
  task automatic test_reset;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid0); end
    n_chk++; if (out_word0 !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0", out_word0); end
    n_chk++; if (out_addr0 !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", out_addr0); end
    n_chk++; if (out_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err0); end
    n_chk++; if (err_count0 !== 16'h0) begin n_fail++; $display("FAIL reset_errcnt: got %h want 0", err_count0); end
    n_chk++; if (out_addr1 !== 8'hF8) begin n_fail++; $display("FAIL reset_addr1: got %h want f8", out_addr1); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
  endtask
  task automatic test_addi;
    @(negedge clk);
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0);
    in_valid0 = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_chk++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL addi_latency: out_valid got %b want 0", out_valid0); end
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid0); end
    n_chk++; if (out_word0 !== 32'h00500093) begin n_fail++; $display("FAIL addi_word: got %h want 00500093", out_word0); end
    n_chk++; if (out_addr0 !== exp_addr) begin n_fail++; $display("FAIL addi_addr: got %h want %h", out_addr0, exp_addr); end
    n_chk++; if (out_err0 !== 1'b0) begin n_fail++; $display("FAIL addi_err: got %b want 0", out_err0); end
    exp_addr += 4;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL addi_drain: out_valid got %b want 0", out_valid0); end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    put(6'd4, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 12'd0);
    in_valid0 = 1'b1;
    @(negedge clk);
    put(6'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 12'd0);
    @(negedge clk);
    in_valid0 = 1'b0;
    n_chk++; if (out_word0 !== 32'hFE208EE3) begin n_fail++; $display("FAIL beq_word: got %h want fe208ee3", out_word0); end
    n_chk++; if (out_addr0 !== exp_addr) begin n_fail++; $display("FAIL beq_addr: got %h want %h", out_addr0, exp_addr); end
    exp_addr += 4;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL lui_valid: got %b want 1", out_valid0); end
    n_chk++; if (out_word0 !== 32'h123452B7) begin n_fail++; $display("FAIL lui_word: got %h want 123452b7", out_word0); end
    n_chk++; if (out_addr0 !== exp_addr) begin n_fail++; $display("FAIL lui_addr: got %h want %h", out_addr0, exp_addr); end
    exp_addr += 4;
  endtask
  task automatic test_errors;
    @(negedge clk);
    put(6'd24, 5'd1, 5'd1, 5'd0, 32'd32, 12'd0);
    in_valid0 = 1'b1;
    @(negedge clk);
    put(6'd5, 5'd0, 5'd1, 5'd2, 32'd3, 12'd0);
    @(negedge clk);
    put(6'd50, 5'd1, 5'd1, 5'd1, 32'd0, 12'd0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (out_valid0 !== 1'b1 || out_err0 !== 1'b1 || out_word0 !== 32'h0)
        begin n_fail++; $display("FAIL err_word%0d: valid %b err %b word %h, want 1 1 00000000", i, out_valid0, out_err0, out_word0); end
      n_chk++; if (out_addr0 !== exp_addr) begin n_fail++; $display("FAIL err_addr%0d: got %h want %h", i, out_addr0, exp_addr); end
      exp_addr += 4;
      @(negedge clk);
      in_valid0 = 1'b0;
    end
    n_chk++; if (err_count0 !== 16'd3) begin n_fail++; $display("FAIL err_count: got %0d want 3", err_count0); end
  endtask
  task automatic test_stall;
    @(negedge clk);
    out_ready0 = 1'b0;
    put(6'd27, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
    in_valid0 = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL stall_ready1: got %b want 1", in_ready0); end
    put(6'd28, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
    @(negedge clk);
    put(6'd32, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL stall_ready_low%0d: got %b want 0", i, in_ready0); end
      n_chk++; if (out_valid0 !== 1'b1 || out_word0 !== 32'h002081B3 || out_addr0 !== exp_addr)
        begin n_fail++; $display("FAIL stall_hold%0d: valid %b word %h addr %h, want 1 002081b3 %h", i, out_valid0, out_word0, out_addr0, exp_addr); end
      if (i < 2) @(negedge clk);
    end
    out_ready0 = 1'b1;
    #1;
    n_chk++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready0); end
    exp_addr += 4;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_chk++; if (out_word0 !== 32'h402081B3 || out_addr0 !== exp_addr)
      begin n_fail++; $display("FAIL stall_sub: word %h addr %h, want 402081b3 %h", out_word0, out_addr0, exp_addr); end
    exp_addr += 4;
    @(negedge clk);
    n_chk++; if (out_word0 !== 32'h0020C1B3 || out_addr0 !== exp_addr)
      begin n_fail++; $display("FAIL stall_xor: word %h addr %h, want 0020c1b3 %h", out_word0, out_addr0, exp_addr); end
    exp_addr += 4;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", out_valid0); end
  endtask
  task automatic test_encodings;
    logic [5:0] kv [12] = '{6'd41, 6'd39, 6'd40, 6'd38, 6'd2, 6'd17, 6'd26, 6'd18, 6'd18, 6'd2, 6'd6, 6'd37};
    logic [4:0] rdv [12] = '{5'd1, 5'd7, 5'd7, 5'd7, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0] r1v [12] = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd0, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0};
    logic [4:0] r2v [12] = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0};
    logic [31:0] immv [12] = '{32'd0, 32'd9, 32'd9, 32'd9, 32'd8, 32'd12, 32'd3, 32'hFFFFF800, 32'd2048,
                               32'hFFF00000, 32'd4096, 32'h000000FF};
    logic [11:0] csrv [12] = '{12'h300, 12'h5, 12'h5, 12'h5, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    logic [31:0] wv [12] = '{32'h300110F3, 32'h00000073, 32'h00100073, 32'h0000100F, 32'h008000EF, 32'h00512623,
                             32'h4030D093, 32'h80000013, 32'h0, 32'h8000006F, 32'h0, 32'h0FF0000F};
    logic ev [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 12) begin
        put(kv[i], rdv[i], r1v[i], r2v[i], immv[i], csrv[i]);
        in_valid0 = 1'b1;
      end else in_valid0 = 1'b0;
      if (i >= 2) begin
        n_chk++; if (out_valid0 !== 1'b1 || out_word0 !== wv[i-2] || out_err0 !== ev[i-2] || out_addr0 !== exp_addr)
          begin n_fail++; $display("FAIL enc%0d: valid %b word %h err %b addr %h, want 1 %h %b %h", i - 2, out_valid0, out_word0, out_err0, out_addr0, wv[i-2], ev[i-2], exp_addr); end
        exp_addr += 4;
      end
    end
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL enc_drain: got %b want 0", out_valid0); end
    n_chk++; if (err_count0 !== 16'd5) begin n_fail++; $display("FAIL enc_errcnt: got %0d want 5", err_count0); end
  endtask
  task automatic test_wrap_clear;
    @(negedge clk);
    out_ready1 = 1'b1;
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd1, 12'd0);
    in_valid1 = 1'b1;
    @(negedge clk);
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd2, 12'd0);
    @(negedge clk);
    put(6'd50, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
    n_chk++; if (out_word1 !== 32'h00100093 || out_addr1 !== 8'hF8)
      begin n_fail++; $display("FAIL wrap0: word %h addr %h, want 00100093 f8", out_word1, out_addr1); end
    @(negedge clk);
    in_valid1 = 1'b0;
    n_chk++; if (out_word1 !== 32'h00200093 || out_addr1 !== 8'hFC)
      begin n_fail++; $display("FAIL wrap1: word %h addr %h, want 00200093 fc", out_word1, out_addr1); end
    @(negedge clk);
    n_chk++; if (out_err1 !== 1'b1 || out_addr1 !== 8'h00)
      begin n_fail++; $display("FAIL wrap2: err %b addr %h, want 1 00", out_err1, out_addr1); end
    @(negedge clk);
    n_chk++; if (out_valid1 !== 1'b0 || err_count1 !== 16'd1)
      begin n_fail++; $display("FAIL wrap_drain: valid %b errcnt %0d, want 0 1", out_valid1, err_count1); end
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd9, 12'd0);
    in_valid1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b1;
    #1;
    n_chk++; if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", in_ready1); end
    @(negedge clk);
    clear1 = 1'b0;
    n_chk++; if (out_valid1 !== 1'b0 || err_count1 !== 16'd0 || out_addr1 !== 8'hF8)
      begin n_fail++; $display("FAIL clear_flush: valid %b errcnt %0d addr %h, want 0 0 f8", out_valid1, err_count1, out_addr1); end
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd3, 12'd0);
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid1 !== 1'b1 || out_word1 !== 32'h00300093 || out_addr1 !== 8'hF8)
      begin n_fail++; $display("FAIL clear_next: valid %b word %h addr %h, want 1 00300093 f8", out_valid1, out_word1, out_addr1); end
  endtask
  task automatic test_async_reset;
    @(negedge clk);
    put(6'd18, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0);
    in_valid0 = 1'b1;
    out_ready0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b1 || out_addr0 !== exp_addr)
      begin n_fail++; $display("FAIL arst_pre: valid %b addr %h, want 1 %h", out_valid0, out_addr0, exp_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid0 !== 1'b0 || out_addr0 !== 32'h0 || err_count0 !== 16'd0)
      begin n_fail++; $display("FAIL arst_now: valid %b addr %h errcnt %0d, want 0 0 0", out_valid0, out_addr0, err_count0); end
    @(negedge clk);
    rst_n = 1'b1;
    put(6'd18, 5'd2, 5'd0, 5'd0, 32'd7, 12'd0);
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid0 !== 1'b1 || out_word0 !== 32'h00700113 || out_addr0 !== 32'h0)
      begin n_fail++; $display("FAIL arst_after: valid %b word %h addr %h, want 1 00700113 0", out_valid0, out_word0, out_addr0); end
  endtask
  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_errors;
    test_stall;
    test_encodings;
    test_wrap_clear;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
